// File: rtl/wb_write_queue_if.sv
// Bus bundle for wb_write_queue: writeback push side, register-file write port, forwarding queries.
// The master modport is the writeback/decode side and the slave modport is the queue itself.
interface wb_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_adr;
    logic [DW-1:0] in_data;
    logic          drain_en;
    logic          RegWrite;
    logic [AW-1:0] writeadr;
    logic [DW-1:0] WriteData;
    logic [AW-1:0] lookup_adr1;
    logic [AW-1:0] lookup_adr2;
    logic          fwd_hit1;
    logic [DW-1:0] fwd_data1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data2;
    logic [CW-1:0] count;

    modport master (
        output flush, in_valid, in_adr, in_data, drain_en, lookup_adr1, lookup_adr2,
        input  in_ready, RegWrite, writeadr, WriteData,
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
    );

    modport slave (
        input  flush, in_valid, in_adr, in_data, drain_en, lookup_adr1, lookup_adr2,
        output in_ready, RegWrite, writeadr, WriteData,
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
    );
endinterface

// File: rtl/wb_write_queue.sv
// Writeback-to-register-file write queue with a registered write port and forwarding lookups.
// Define WBQ_FORWARD_EN to build the forwarding comparators; otherwise fwd_* outputs are tied to 0.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              reset,
    wb_write_queue_if.slave   wq
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] adr_q  [DEPTH];
    logic [AW-1:0] adr_d  [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          reg_write_q, reg_write_d;
    logic [AW-1:0] write_adr_q, write_adr_d;
    logic [DW-1:0] write_data_q, write_data_d;
    logic          push;
    logic          pop;

    assign wq.in_ready  = (count_q != CW'(DEPTH));
    assign wq.count     = count_q;
    assign wq.RegWrite  = reg_write_q;
    assign wq.writeadr  = write_adr_q;
    assign wq.WriteData = write_data_q;

    always_comb begin
        // Register 0 writes complete the handshake but are never stored.
        push         = wq.in_valid && wq.in_ready && !wq.flush && (wq.in_adr != '0);
        pop          = wq.drain_en && (count_q != '0) && !wq.flush;
        adr_d        = adr_q;
        data_d       = data_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        reg_write_d  = 1'b0;
        write_adr_d  = write_adr_q;
        write_data_d = write_data_q;

        if (push) begin
            adr_d[tail_q]  = wq.in_adr;
            data_d[tail_q] = wq.in_data;
            tail_d         = tail_q + PW'(1);
        end

        if (pop) begin
            reg_write_d  = 1'b1;
            write_adr_d  = adr_q[head_q];
            write_data_d = data_q[head_q];
            head_d       = head_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (wq.flush) begin
            adr_d   = '{default: '0};
            data_d  = '{default: '0};
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            adr_q        <= '{default: '0};
            data_q       <= '{default: '0};
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            reg_write_q  <= 1'b0;
            write_adr_q  <= '0;
            write_data_q <= '0;
        end else begin
            adr_q        <= adr_d;
            data_q       <= data_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            reg_write_q  <= reg_write_d;
            write_adr_q  <= write_adr_d;
            write_data_q <= write_data_d;
        end
    end

`ifdef WBQ_FORWARD_EN
    // Scan oldest-to-youngest so later matches overwrite; the output stage is older than any queued entry.
    function automatic logic [DW:0] fwd_search(input logic [AW-1:0] qadr);
        logic          hit;
        logic [DW-1:0] dat;
        logic [PW-1:0] idx;
        hit = 1'b0;
        dat = '0;
        if (reg_write_q && (write_adr_q == qadr)) begin
            hit = 1'b1;
            dat = write_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (adr_q[idx] == qadr)) begin
                hit = 1'b1;
                dat = data_q[idx];
            end
        end
        if (qadr == '0) begin
            hit = 1'b0;
            dat = '0;
        end
        return {hit, dat};
    endfunction

    assign {wq.fwd_hit1, wq.fwd_data1} = fwd_search(wq.lookup_adr1);
    assign {wq.fwd_hit2, wq.fwd_data2} = fwd_search(wq.lookup_adr2);
`else
    logic unused_lookup;

    assign unused_lookup = ^{wq.lookup_adr1, wq.lookup_adr2};
    assign wq.fwd_hit1   = 1'b0;
    assign wq.fwd_data1  = '0;
    assign wq.fwd_hit2   = 1'b0;
    assign wq.fwd_data2  = '0;
`endif

endmodule
